// File: rtl/fc_rx_deframer_if.sv
// Stream bundle for fc_rx_deframer: 36-bit PHY words in, Avalon-ST frame words out.
// slave = deframer side (consumes PHY words, sources frame beats).
// master = PHY/sink side (sources PHY words, drives ready, observes beats).
interface fc_rx_deframer_if;
  logic [35:0] avrx_data;
  logic        avrx_valid;
  logic [31:0] userrx_data;
  logic        userrx_valid;
  logic        userrx_ready;
  logic        userrx_startofpacket;
  logic        userrx_endofpacket;
  logic        userrx_error;

  modport slave (
    input  avrx_data, avrx_valid, userrx_ready,
    output userrx_data, userrx_valid, userrx_startofpacket,
           userrx_endofpacket, userrx_error
  );

  modport master (
    output avrx_data, avrx_valid, userrx_ready,
    input  userrx_data, userrx_valid, userrx_startofpacket,
           userrx_endofpacket, userrx_error
  );
endinterface

// File: rtl/fc_rx_deframer.sv
// FC RX deframer: hunts SOF/EOF in the PHY word stream, emits frames as Avalon-ST packets.
// Latency: a data word is pushed when the next DATA/EOF arrives; valid rises the cycle after the push.
// Backpressure: PHY cannot stall; FIFO absorbs it, overflow truncates the frame with an error beat.
// Optional CRC-32 check on frame data enabled by defining FC_DEFRAMER_CRC_EN.
module fc_rx_deframer #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_WORDS  = 537
) (
  input  logic            rx_clk,
  input  logic            reset,
  input  logic            link_active,
  fc_rx_deframer_if.slave rx,
  output logic [15:0]     frame_count,
  output logic [15:0]     error_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {HUNT, INFRAME, DISCARD} state_t;
  typedef struct packed {
    logic        sop;
    logic        eop;
    logic        err;
    logic [31:0] data;
  } ent_t;

  state_t        fsm_q, fsm_d;
  logic          hold_vld_q, hold_vld_d;
  logic          hold_sop_q, hold_sop_d;
  logic [31:0]   hold_dat_q, hold_dat_d;
  logic          first_q, first_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_term_q, pend_term_d;
  logic          frame_wr_q, frame_wr_d;   // an entry of the current frame already sits in the FIFO
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [15:0]   error_count_q, error_count_d;
  ent_t          mem_q [FIFO_DEPTH];

  logic [3:0] datak;
  logic [7:0] b3, b2, b1, b0;
  logic       k_hdr, is_data, is_sof, is_eof, is_eofa;
  logic       crc_bad;
  logic       empty, full, pop;
  ent_t       head;
  logic       close_req, close_err, push_req, drop, wr_en;
  ent_t       push_ent, wr_ent;

  assign datak = rx.avrx_data[35:32];
  assign b3    = rx.avrx_data[31:24];
  assign b2    = rx.avrx_data[23:16];
  assign b1    = rx.avrx_data[15:8];
  assign b0    = rx.avrx_data[7:0];

  // Classify the incoming word as DATA, SOF, EOF or other K word
  always_comb begin
    k_hdr   = (datak == 4'b1000) && (b3 == 8'hBC) && (b1 == b0);
    is_data = (datak == 4'b0000);
    is_sof  = k_hdr && (b2 == 8'hB5) &&
              (b1 inside {8'h35, 8'h36, 8'h37, 8'h55, 8'h56, 8'h57, 8'h58});
    is_eof  = k_hdr && ((b2 == 8'h95) || (b2 == 8'hB5)) &&
              (b1 inside {8'h75, 8'hD5, 8'hF5});
    is_eofa = is_eof && (b1 == 8'hF5);
  end

`ifdef FC_DEFRAMER_CRC_EN
  logic [31:0] crc_q, crc_d;

  // MSB-first CRC-32 over one 32-bit word
  function automatic logic [31:0] crc32_word(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    end
    return r;
  endfunction

  // Good frame (data plus its CRC word) leaves the fixed residue
  assign crc_bad = (crc_q != 32'hC704DD7B);
`else
  assign crc_bad = 1'b0;
`endif

  // Show-ahead FIFO status and output view
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop   = !empty && rx.userrx_ready;

  assign rx.userrx_valid         = !empty;
  assign rx.userrx_data          = empty ? 32'h0 : head.data;
  assign rx.userrx_startofpacket = !empty && head.sop;
  assign rx.userrx_endofpacket   = !empty && head.eop;
  assign rx.userrx_error         = !empty && head.err;
  assign frame_count             = frame_count_q;
  assign error_count             = error_count_q;

  // Next-state: FSM, hold register, FIFO write/overflow handling, counters
  always_comb begin
    fsm_d         = fsm_q;
    hold_vld_d    = hold_vld_q;
    hold_sop_d    = hold_sop_q;
    hold_dat_d    = hold_dat_q;
    first_d       = first_q;
    cnt_d         = cnt_q;
    pend_term_d   = pend_term_q;
    frame_wr_d    = frame_wr_q;
    close_req     = 1'b0;
    close_err     = 1'b0;
    push_req      = 1'b0;
    push_ent      = '0;
    drop          = 1'b0;
    wr_en         = 1'b0;
    wr_ent        = '0;
`ifdef FC_DEFRAMER_CRC_EN
    crc_d         = crc_q;
`endif

    if (rx.avrx_valid) begin
      case (fsm_q)
        HUNT: begin
          if (is_sof && link_active) begin
            fsm_d   = INFRAME;
            cnt_d   = '0;
            first_d = 1'b1;
`ifdef FC_DEFRAMER_CRC_EN
            crc_d   = 32'hFFFFFFFF;
`endif
          end
        end
        INFRAME: begin
          if (!link_active) begin
            close_req = 1'b1;
            close_err = 1'b1;
            fsm_d     = HUNT;
          end else if (is_data) begin
            if (cnt_q == CW'(MAX_WORDS)) begin
              close_req = 1'b1;
              close_err = 1'b1;
              fsm_d     = DISCARD;
            end else begin
              push_req   = hold_vld_q;
              push_ent   = '{sop: hold_sop_q, eop: 1'b0, err: 1'b0, data: hold_dat_q};
              hold_vld_d = 1'b1;
              hold_sop_d = first_q;
              hold_dat_d = rx.avrx_data[31:0];
              first_d    = 1'b0;
              cnt_d      = cnt_q + CW'(1);
`ifdef FC_DEFRAMER_CRC_EN
              crc_d      = crc32_word(crc_q, rx.avrx_data[31:0]);
`endif
            end
          end else if (is_eof) begin
            close_req = 1'b1;
            close_err = is_eofa || crc_bad;
            fsm_d     = HUNT;
          end else if (is_sof) begin
            // abort the open frame and start the new one on this same word
            close_req = 1'b1;
            close_err = 1'b1;
            cnt_d     = '0;
            first_d   = 1'b1;
`ifdef FC_DEFRAMER_CRC_EN
            crc_d     = 32'hFFFFFFFF;
`endif
          end else begin
            close_req = 1'b1;
            close_err = 1'b1;
            fsm_d     = HUNT;
          end
        end
        DISCARD: begin
          if (is_eof) begin
            fsm_d = HUNT;
          end else if (is_sof && link_active) begin
            fsm_d   = INFRAME;
            cnt_d   = '0;
            first_d = 1'b1;
`ifdef FC_DEFRAMER_CRC_EN
            crc_d   = 32'hFFFFFFFF;
`endif
          end
        end
        default: fsm_d = HUNT;
      endcase
    end

    // Closing a frame flushes the hold word as eop; an empty frame is only counted
    if (close_req) begin
      hold_vld_d = 1'b0;
      if (hold_vld_q) begin
        push_req = 1'b1;
        push_ent = '{sop: hold_sop_q, eop: 1'b1, err: close_err, data: hold_dat_q};
      end else begin
        drop = 1'b1;
      end
    end

    if (pend_term_q) begin
      // frame pushes are suppressed until the truncation beat is written
      if (!full || pop) begin
        wr_en       = 1'b1;
        wr_ent      = '{sop: 1'b0, eop: 1'b1, err: 1'b1, data: 32'h0};
        pend_term_d = 1'b0;
        frame_wr_d  = 1'b0;
      end
    end else if (push_req) begin
      if (full && !pop) begin
        fsm_d      = DISCARD;
        hold_vld_d = 1'b0;
        if (frame_wr_q) pend_term_d = 1'b1;
        else            drop        = 1'b1;
      end else begin
        wr_en      = 1'b1;
        wr_ent     = push_ent;
        frame_wr_d = !push_ent.eop;
      end
    end

    wr_ptr_d      = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d      = rd_ptr_q + (AW+1)'(pop);
    frame_count_d = frame_count_q + 16'(pop && head.eop && !head.err);
    error_count_d = error_count_q + 16'(pop && head.eop && head.err) + 16'(drop);
  end

  // State, pointer and counter registers
  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      fsm_q         <= HUNT;
      hold_vld_q    <= 1'b0;
      hold_sop_q    <= 1'b0;
      hold_dat_q    <= '0;
      first_q       <= 1'b0;
      cnt_q         <= '0;
      pend_term_q   <= 1'b0;
      frame_wr_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_count_q <= '0;
      error_count_q <= '0;
`ifdef FC_DEFRAMER_CRC_EN
      crc_q         <= 32'hFFFFFFFF;
`endif
    end else begin
      fsm_q         <= fsm_d;
      hold_vld_q    <= hold_vld_d;
      hold_sop_q    <= hold_sop_d;
      hold_dat_q    <= hold_dat_d;
      first_q       <= first_d;
      cnt_q         <= cnt_d;
      pend_term_q   <= pend_term_d;
      frame_wr_q    <= frame_wr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
`ifdef FC_DEFRAMER_CRC_EN
      crc_q         <= crc_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since outputs are gated by empty
  always_ff @(posedge rx_clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_ent;
  end
endmodule

// File: tb/tb_fc_rx_deframer.sv
// Bench for fc_rx_deframer: scoreboard of expected beats, checked by a monitor on the falling edge.
module tb_fc_rx_deframer;
  localparam logic [35:0] SOF_I3 = {4'h8, 32'hBCB55656};
  localparam logic [35:0] EOF_T  = {4'h8, 32'hBC957575};
  localparam logic [35:0] EOF_N  = {4'h8, 32'hBC95D5D5};
  localparam logic [35:0] EOF_A  = {4'h8, 32'hBCB5F5F5};
  localparam logic [35:0] IDLE_K = {4'h8, 32'hBC95B5B5};
  localparam int          BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        link_active = 1'b1;
  logic [15:0] frame_count, error_count;
  logic        rand_rdy = 1'b0;
  logic        fixed_rdy = 1'b1;
  logic [34:0] exp_q[$];   // {sop, eop, err, data}
  int          checks = 0;
  int          failures = 0;

  fc_rx_deframer_if bus();

  fc_rx_deframer dut (
    .rx_clk      (clk),
    .reset       (rst),
    .link_active (link_active),
    .rx          (bus),
    .frame_count (frame_count),
    .error_count (error_count)
  );

  always #5 clk = ~clk;

  // sink ready: fixed or random, changed just after the rising edge
  initial begin
    bus.userrx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.userrx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
    end
  end

  // monitor: every accepted beat must match the head of the scoreboard
  initial begin
    logic [34:0] got, exp;
    forever begin
      @(negedge clk);
      if (!rst && bus.userrx_valid && bus.userrx_ready) begin
        got = {bus.userrx_startofpacket, bus.userrx_endofpacket, bus.userrx_error, bus.userrx_data};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected: got sop=%b eop=%b err=%b data=%h, none expected",
                   got[34], got[33], got[32], got[31:0]);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL beat: got sop=%b eop=%b err=%b data=%h, expected sop=%b eop=%b err=%b data=%h",
                     got[34], got[33], got[32], got[31:0], exp[34], exp[33], exp[32], exp[31:0]);
          end
        end
      end
    end
  end

  // hard stop if something never terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic put_l(input logic [35:0] w, input logic la);
    @(posedge clk); #1;
    bus.avrx_data  = w;
    bus.avrx_valid = 1'b1;
    link_active    = la;
  endtask

  task automatic put(input logic [35:0] w);
    put_l(w, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.avrx_valid = 1'b0;
      bus.avrx_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.avrx_valid = 1'b0;
    bus.avrx_data  = '0;
    link_active = 1'b1;
    rand_rdy  = 1'b0;
    fixed_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    idle(1);
    while ((exp_q.size() != 0 || bus.userrx_valid) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= BUDGET) begin
      failures++;
      $display("FAIL %s_drain: %0d beats outstanding, valid=%b after %0d cycles, required 0",
               name, exp_q.size(), bus.userrx_valid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.avrx_valid = 1'b0;
    bus.avrx_data  = '0;
    @(negedge clk);
    checks++;
    if ({bus.userrx_valid, bus.userrx_startofpacket, bus.userrx_endofpacket,
         bus.userrx_error, bus.userrx_data} !== 36'h0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b sop=%b eop=%b err=%b data=%h, required all 0",
               bus.userrx_valid, bus.userrx_startofpacket, bus.userrx_endofpacket,
               bus.userrx_error, bus.userrx_data);
    end
    checks++;
    if (frame_count !== 16'd0 || error_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts: got frame=%0d error=%0d, required 0/0", frame_count, error_count);
    end
    do_reset();
  endtask

  task automatic test_basic();
    logic [31:0] w;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      w = 32'h11111111 * i;
      exp_q.push_back({i == 1, i == 5, 1'b0, w});
    end
    put(SOF_I3);
    for (int i = 1; i <= 5; i++) begin
      w = 32'h11111111 * i;
      put({4'h0, w});
    end
    put(EOF_T);
    drain("basic");
    checks++;
    if (frame_count !== 16'd1 || error_count !== 16'd0) begin
      failures++;
      $display("FAIL basic_counts: got frame=%0d error=%0d, required 1/0", frame_count, error_count);
    end
  endtask

  task automatic test_eofa();
    logic [31:0] w;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      w = 32'h11111111 * i;
      exp_q.push_back({i == 1, i == 5, i == 5, w});
    end
    put(SOF_I3);
    for (int i = 1; i <= 5; i++) begin
      w = 32'h11111111 * i;
      put({4'h0, w});
    end
    put(EOF_A);
    drain("eofa");
    checks++;
    if (frame_count !== 16'd0 || error_count !== 16'd1) begin
      failures++;
      $display("FAIL eofa_counts: got frame=%0d error=%0d, required 0/1", frame_count, error_count);
    end
  endtask

  task automatic test_maxlen();
    do_reset();
    for (int i = 1; i <= 537; i++)
      exp_q.push_back({i == 1, i == 537, i == 537, 32'hA0000000 + 32'(i)});
    put(SOF_I3);
    for (int i = 1; i <= 600; i++) put({4'h0, 32'hA0000000 + 32'(i)});
    put(EOF_N);
    idle(3);
    // words outside a frame must produce nothing
    for (int i = 0; i < 3; i++) put({4'h0, 32'hDEAD0000 + 32'(i)});
    put(EOF_T);
    drain("maxlen");
    checks++;
    if (frame_count !== 16'd0 || error_count !== 16'd1) begin
      failures++;
      $display("FAIL maxlen_counts: got frame=%0d error=%0d, required 0/1", frame_count, error_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fixed_rdy = 1'b0;
    put(SOF_I3);
    for (int i = 1; i <= 20; i++) put({4'h0, 32'hB0000000 + 32'(i)});
    put(EOF_T);
    idle(4);
    @(negedge clk);
    checks++;
    if (bus.userrx_valid !== 1'b1 || bus.userrx_startofpacket !== 1'b1 ||
        bus.userrx_data !== 32'hB0000001) begin
      failures++;
      $display("FAIL overflow_head: got valid=%b sop=%b data=%h, required 1/1/b0000001",
               bus.userrx_valid, bus.userrx_startofpacket, bus.userrx_data);
    end
    // the FIFO holds words 1..16; word 17 overflows and the frame is truncated
    for (int i = 1; i <= 16; i++) exp_q.push_back({i == 1, 1'b0, 1'b0, 32'hB0000000 + 32'(i)});
    exp_q.push_back({1'b0, 1'b1, 1'b1, 32'h0});
    fixed_rdy = 1'b1;
    drain("overflow");
    checks++;
    if (frame_count !== 16'd0 || error_count !== 16'd1) begin
      failures++;
      $display("FAIL overflow_counts: got frame=%0d error=%0d, required 0/1", frame_count, error_count);
    end
  endtask

  task automatic test_abort_other();
    do_reset();
    for (int i = 1; i <= 3; i++) exp_q.push_back({i == 1, i == 3, i == 3, 32'hC0000000 + 32'(i)});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 32'hC1000001});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 32'hC1000002});
    put(SOF_I3);
    for (int i = 1; i <= 3; i++) put({4'h0, 32'hC0000000 + 32'(i)});
    put(IDLE_K);
    put(SOF_I3);
    put({4'h0, 32'hC1000001});
    put({4'h0, 32'hC1000002});
    put(EOF_T);
    drain("abort_other");
    checks++;
    if (frame_count !== 16'd1 || error_count !== 16'd1) begin
      failures++;
      $display("FAIL abort_other_counts: got frame=%0d error=%0d, required 1/1", frame_count, error_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rand_rdy = 1'b1;
    // SOF inside a frame closes it with error and opens a single-word frame
    exp_q.push_back({1'b1, 1'b0, 1'b0, 32'hD0000001});
    exp_q.push_back({1'b0, 1'b1, 1'b1, 32'hD0000002});
    exp_q.push_back({1'b1, 1'b1, 1'b0, 32'hD1000001});
    put(SOF_I3);
    put({4'h0, 32'hD0000001});
    put({4'h0, 32'hD0000002});
    put({4'h8, 32'hBCB53737});
    put({4'h0, 32'hD1000001});
    put(EOF_T);
    // empty frame: nothing emitted, counted as error
    put({4'h8, 32'hBCB55555});
    put(EOF_N);
    // link down: SOF ignored, nothing emitted
    put_l(SOF_I3, 1'b0);
    put_l({4'h0, 32'hEEEE0001}, 1'b0);
    put_l(EOF_T, 1'b0);
    // gaps mid-frame are harmless; link loss closes with error
    exp_q.push_back({1'b1, 1'b0, 1'b0, 32'hD2000001});
    exp_q.push_back({1'b0, 1'b1, 1'b1, 32'hD2000002});
    put(SOF_I3);
    put({4'h0, 32'hD2000001});
    idle(3);
    put({4'h0, 32'hD2000002});
    put_l({4'h0, 32'hD2000003}, 1'b0);
    drain("back_to_back");
    checks++;
    if (frame_count !== 16'd1 || error_count !== 16'd3) begin
      failures++;
      $display("FAIL back_to_back_counts: got frame=%0d error=%0d, required 1/3", frame_count, error_count);
    end
    rand_rdy = 1'b0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    fixed_rdy = 1'b0;
    put(SOF_I3);
    for (int i = 1; i <= 5; i++) put({4'h0, 32'hF0000000 + 32'(i)});
    idle(3);
    @(negedge clk);
    checks++;
    if (bus.userrx_valid !== 1'b1 || bus.userrx_data !== 32'hF0000001) begin
      failures++;
      $display("FAIL midreset_pre: got valid=%b data=%h, required 1/f0000001",
               bus.userrx_valid, bus.userrx_data);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.userrx_valid, bus.userrx_startofpacket, bus.userrx_endofpacket,
         bus.userrx_error, bus.userrx_data} !== 36'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got valid=%b sop=%b eop=%b err=%b data=%h, required all 0",
               bus.userrx_valid, bus.userrx_startofpacket, bus.userrx_endofpacket,
               bus.userrx_error, bus.userrx_data);
    end
    do_reset();
    idle(8);
    exp_q.push_back({1'b1, 1'b1, 1'b0, 32'hF1000001});
    put(SOF_I3);
    put({4'h0, 32'hF1000001});
    put(EOF_T);
    drain("midreset");
    checks++;
    if (frame_count !== 16'd1 || error_count !== 16'd0) begin
      failures++;
      $display("FAIL midreset_counts: got frame=%0d error=%0d, required 1/0", frame_count, error_count);
    end
  endtask

`ifdef FC_DEFRAMER_CRC_EN
  function automatic logic [31:0] tb_crc(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  task automatic test_crc();
    logic [31:0] w [3];
    logic [31:0] c;
    do_reset();
    w[0] = 32'h01234567; w[1] = 32'h89ABCDEF; w[2] = 32'h0F1E2D3C;
    for (int pass = 0; pass < 2; pass++) begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) c = tb_crc(c, w[i]);
      c = ~c;
      if (pass == 1) w[1] = w[1] ^ 32'h00000100;
      for (int i = 0; i < 3; i++) exp_q.push_back({i == 0, 1'b0, 1'b0, w[i]});
      exp_q.push_back({1'b0, 1'b1, pass == 1, c});
      put(SOF_I3);
      for (int i = 0; i < 3; i++) put({4'h0, w[i]});
      put({4'h0, c});
      put(EOF_T);
    end
    drain("crc");
    checks++;
    if (frame_count !== 16'd1 || error_count !== 16'd1) begin
      failures++;
      $display("FAIL crc_counts: got frame=%0d error=%0d, required 1/1", frame_count, error_count);
    end
  endtask
`endif

  initial begin
    bus.avrx_valid = 1'b0;
    bus.avrx_data  = '0;
    test_reset();
    test_basic();
    test_eofa();
    test_maxlen();
    test_overflow();
    test_abort_other();
    test_back_to_back();
    test_reset_midframe();
`ifdef FC_DEFRAMER_CRC_EN
    test_crc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
